// File: rtl/submdl_rotctrl.sv
// Sequencer for the submdl_rot8 8-phase one-hot rotator: runs N full rotations per
// request, drains the ring, watches ring integrity and supports abort.
module submdl_rotctrl #(
    parameter int unsigned CNTW = 12
) (
    input  logic            i_CLK,
    input  logic            i_RST,
    input  logic            i_CEN_n,
    input  logic            i_START,
    input  logic            i_ABORT,
    input  logic [CNTW-1:0] i_STEPS,
    input  logic [7:0]      i_ROT8,
    output logic            o_STOP_n,
    output logic            o_BUSY,
    output logic            o_DONE,
    output logic            o_ABORTED,
    output logic            o_ERR,
    output logic [CNTW-1:0] o_STEP_CNT,
    output logic [2:0]      o_PHASE,
    output logic            o_PHASE_VLD
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN
    } state_e;

    localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic            stop_n_q, stop_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic            abort_now;

    always_comb begin
        o_PHASE = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i_ROT8[i]) o_PHASE = i[2:0];
        end
    end

    assign o_PHASE_VLD = $onehot(i_ROT8);

    // An abort sampled on this edge must already hold off re-injection at 8'h80,
    // so the registered stop is gated by the abort request itself.
    assign abort_now = i_ABORT && !i_CEN_n && (state_q == PRIME || state_q == RUN);

    assign o_STOP_n   = stop_n_q && !abort_now;
    assign o_BUSY     = busy_q;
    assign o_DONE     = done_q;
    assign o_ABORTED  = aborted_q;
    assign o_ERR      = err_q;
    assign o_STEP_CNT = cnt_q;

    always_comb begin
        state_d   = state_q;
        stop_n_d  = stop_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        if (!i_CEN_n) begin
            unique case (state_q)
                IDLE: begin
                    if (i_START) begin
                        if (i_STEPS == '0) begin
                            done_d    = 1'b1;
                            err_d     = 1'b0;
                            aborted_d = 1'b0;
                            cnt_d     = '0;
                        end else if (i_ROT8 == 8'h00) begin
                            rem_d     = i_STEPS;
                            cnt_d     = '0;
                            err_d     = 1'b0;
                            aborted_d = 1'b0;
                            stop_n_d  = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = PRIME;
                        end
                    end
                end
                PRIME: begin
                    if (i_ROT8 != 8'h00 && i_ROT8 != 8'h01) begin
                        err_d    = 1'b1;
                        stop_n_d = 1'b0;
                        state_d  = DRAIN;
                    end else if (i_ABORT) begin
                        aborted_d = 1'b1;
                        stop_n_d  = 1'b0;
                        state_d   = DRAIN;
                    end else if (i_ROT8 == 8'h01) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!o_PHASE_VLD) begin
                        err_d    = 1'b1;
                        stop_n_d = 1'b0;
                        state_d  = DRAIN;
                    end else begin
                        if (i_ROT8 == 8'h80) begin
                            cnt_d = cnt_q + ONE;
                            rem_d = rem_q - ONE;
                        end
                        if (i_ABORT) begin
                            aborted_d = 1'b1;
                            stop_n_d  = 1'b0;
                            state_d   = DRAIN;
                        end else if (i_ROT8 == 8'h80 && rem_q == ONE) begin
                            stop_n_d = 1'b0;
                            state_d  = DRAIN;
                        end else if (i_ROT8 == 8'h40 && rem_q == ONE) begin
                            stop_n_d = 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    stop_n_d = 1'b0;
                    if (i_ROT8 == 8'h00) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= IDLE;
            stop_n_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            stop_n_q  <= stop_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
        end
    end

endmodule

// File: tb/tb_submdl_rotctrl.sv
// Directed bench for submdl_rotctrl driving a behavioural 8-phase rotator
// closed-loop through o_STOP_n / i_ROT8.
module tb_submdl_rotctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] steps = 12'd0;
    logic [7:0]  rot_m = 8'h00;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;
    logic [7:0]  rot_fb;
    logic        stop_n, busy, done, aborted, err, vld;
    logic [11:0] cnt;
    logic [2:0]  phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Rotator reference: shift, inject into bit0 when bits 6:0 are empty and stop_n=1.
    always @(posedge clk) begin
        if (!cen_n) rot_m <= {rot_m[6:0], (rot_m[6:0] == 7'd0) && stop_n};
    end

    assign rot_fb = force_en ? force_val : rot_m;

    submdl_rotctrl #(.CNTW(12)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_CEN_n     (cen_n),
        .i_START     (start),
        .i_ABORT     (abort),
        .i_STEPS     (steps),
        .i_ROT8      (rot_fb),
        .o_STOP_n    (stop_n),
        .o_BUSY      (busy),
        .o_DONE      (done),
        .o_ABORTED   (aborted),
        .o_ERR       (err),
        .o_STEP_CNT  (cnt),
        .o_PHASE     (phase),
        .o_PHASE_VLD (vld)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (n < max) begin
            step();
            n++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (stop_n !== 1'b0) begin errors++; $display("FAIL reset_stop: got %0b expected 0", stop_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %0b expected 0", aborted); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (cnt !== 12'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++; if (phase !== 3'd0 || vld !== 1'b0) begin errors++; $display("FAIL reset_phase: got %0d/%0b expected 0/0", phase, vld); end
    endtask

    task automatic test_run3();
        int highs;
        int dones;
        int done_at;
        int exp_cnt;
        steps = 12'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || stop_n !== 1'b1) begin errors++; $display("FAIL run3_accept: got busy=%0b stop=%0b expected 1/1", busy, stop_n); end
        highs = 1;
        dones = 0;
        done_at = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (stop_n) highs++;
            if (done) begin dones++; done_at = k; end
            exp_cnt = (k - 1) / 8;
            if (exp_cnt > 3) exp_cnt = 3;
            checks++; if (cnt !== 12'(exp_cnt)) begin errors++; $display("FAIL run3_cnt k=%0d: got %0d expected %0d", k, cnt, exp_cnt); end
            if (k <= 24) begin
                checks++; if (phase !== 3'((k - 1) % 8) || vld !== 1'b1) begin errors++; $display("FAIL run3_phase k=%0d: got %0d/%0b expected %0d/1", k, phase, vld, (k - 1) % 8); end
            end
            if (k == 25) begin
                checks++; if (rot_m !== 8'h00) begin errors++; $display("FAIL run3_ring_empty: got %02h expected 00", rot_m); end
            end
        end
        checks++; if (highs != 24) begin errors++; $display("FAIL run3_stop_high: got %0d edges expected 24", highs); end
        checks++; if (dones != 1 || done_at != 26) begin errors++; $display("FAIL run3_done: got %0d pulses at %0d expected 1 at 26", dones, done_at); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run3_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_half_rate();
        steps = 12'd1;
        cen_n = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            cen_n = (c % 2 == 1);
            step();
            checks++; if (stop_n !== (c < 16)) begin errors++; $display("FAIL half_stop c=%0d: got %0b expected %0b", c, stop_n, (c < 16)); end
            checks++; if (done !== (c == 20)) begin errors++; $display("FAIL half_done c=%0d: got %0b expected %0b", c, done, (c == 20)); end
            if (c == 18) begin
                checks++; if (cnt !== 12'd1 || rot_m !== 8'h00) begin errors++; $display("FAIL half_last: got cnt=%0d ring=%02h expected 1/00", cnt, rot_m); end
            end
        end
        cen_n = 1'b0;
        checks++; if (rot_m !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL half_end: got ring=%02h busy=%0b expected 00/0", rot_m, busy); end
    endtask

    task automatic test_abort();
        steps = 12'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) step();
        checks++; if (rot_fb !== 8'h80 || cnt !== 12'd4) begin errors++; $display("FAIL abort_pre: got ring=%02h cnt=%0d expected 80/4", rot_fb, cnt); end
        abort = 1'b1;
        #1;
        checks++; if (stop_n !== 1'b0) begin errors++; $display("FAIL abort_stop: got %0b expected 0", stop_n); end
        step();
        abort = 1'b0;
        checks++; if (cnt !== 12'd5) begin errors++; $display("FAIL abort_cnt: got %0d expected 5", cnt); end
        checks++; if (aborted !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL abort_flags: got ab=%0b err=%0b expected 1/0", aborted, err); end
        checks++; if (rot_m !== 8'h00) begin errors++; $display("FAIL abort_ring: got %02h expected 00", rot_m); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_done: got done=%0b busy=%0b expected 1/0", done, busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_width: got %0b expected 0", done); end
    endtask

    task automatic test_error();
        int n;
        steps = 12'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        force_val = 8'h88;
        force_en = 1'b1;
        step();
        force_en = 1'b0;
        checks++; if (err !== 1'b1 || stop_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_detect: got err=%0b stop=%0b busy=%0b expected 1/0/1", err, stop_n, busy); end
        wait_done(12, n);
        checks++; if (done !== 1'b1 || n != 5) begin errors++; $display("FAIL err_drain: got done=%0b after %0d edges expected 1 after 5", done, n); end
        steps = 12'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_clear: got err=%0b busy=%0b expected 0/1", err, busy); end
        for (int k = 1; k <= 3; k++) step();
        force_en = 1'b1;
        abort = 1'b1;
        step();
        force_en = 1'b0;
        abort = 1'b0;
        checks++; if (err !== 1'b1 || aborted !== 1'b0) begin errors++; $display("FAIL err_prio: got err=%0b ab=%0b expected 1/0", err, aborted); end
        wait_done(12, n);
        checks++; if (done !== 1'b1 || n != 6) begin errors++; $display("FAIL err_prio_drain: got done=%0b after %0d edges expected 1 after 6", done, n); end
    endtask

    task automatic test_zero_and_busy();
        int n;
        steps = 12'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || stop_n !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%0b busy=%0b stop=%0b expected 1/0/0", done, busy, stop_n); end
        checks++; if (err !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL zero_flags: got err=%0b ab=%0b expected 0/0", err, aborted); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_width: got %0b expected 0", done); end
        steps = 12'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        steps = 12'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(30, n);
        checks++; if (done !== 1'b1 || n != 12) begin errors++; $display("FAIL busy_len: got done=%0b after %0d edges expected 1 after 12", done, n); end
        checks++; if (cnt !== 12'd2 || busy !== 1'b0) begin errors++; $display("FAIL busy_cnt: got cnt=%0d busy=%0b expected 2/0", cnt, busy); end
    endtask

    task automatic test_reset_midrun();
        int n;
        logic [7:0] prev;
        logic accepted;
        steps = 12'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        #2 rst = 1'b1;
        #1;
        checks++; if (stop_n !== 1'b0 || busy !== 1'b0 || cnt !== 12'd0) begin errors++; $display("FAIL rst_async: got stop=%0b busy=%0b cnt=%0d expected 0/0/0", stop_n, busy, cnt); end
        #1 rst = 1'b0;
        start = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 12 && !accepted; i++) begin
            prev = rot_m;
            step();
            if (prev != 8'h00) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_refuse ring=%02h: got busy=%0b expected 0", prev, busy); end
            end else begin
                checks++; if (busy !== 1'b1 || i != 5) begin errors++; $display("FAIL rst_accept: got busy=%0b at try %0d expected 1 at 5", busy, i); end
                accepted = 1'b1;
            end
        end
        start = 1'b0;
        checks++; if (accepted !== 1'b1) begin errors++; $display("FAIL rst_accept_timeout: got %0b expected 1", accepted); end
        wait_done(60, n);
        checks++; if (done !== 1'b1 || n != 42 || cnt !== 12'd5) begin errors++; $display("FAIL rst_rerun: got done=%0b n=%0d cnt=%0d expected 1/42/5", done, n, cnt); end
    endtask

    initial begin
        test_reset();
        test_run3();
        test_half_rate();
        test_abort();
        test_error();
        test_zero_and_busy();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
